// File: rtl/mfcc_loop_pkg.sv
// Shared constants for the MFCC two-level loop sequencer: FSM encoding,
// default index width and the stall-counter width with its saturating increment.
package mfcc_loop_pkg;

    localparam int CNT_W_DEF   = 7;
    localparam int STALL_CNT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Saturating +1 so the stall counter sticks at all-ones instead of wrapping
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        if (v == {STALL_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/nested_loop_ctrl_if.sv
// Control/status bundle between the top-level FSM (master) and the loop sequencer (slave).
// The stall_cnt member exists only when NESTED_LOOP_STALL_CNT_EN is defined.
interface nested_loop_ctrl_if #(
    parameter int CNT_W     = 7,
    parameter int OUT_CNT_W = CNT_W
);
    import mfcc_loop_pkg::*;

    logic                 start;
    logic                 abort;
    logic                 stall;
    logic [CNT_W-1:0]     inner_limit;
    logic [OUT_CNT_W-1:0] outer_limit;
    logic                 step_valid;
    logic [CNT_W-1:0]     inner_idx;
    logic [OUT_CNT_W-1:0] outer_idx;
    logic                 inner_last;
    logic                 outer_last;
    logic                 busy;
    logic                 done;
`ifdef NESTED_LOOP_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`endif

    modport master (
        output start, abort, stall, inner_limit, outer_limit,
        input  step_valid, inner_idx, outer_idx, inner_last, outer_last, busy, done
`ifdef NESTED_LOOP_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  start, abort, stall, inner_limit, outer_limit,
        output step_valid, inner_idx, outer_idx, inner_last, outer_last, busy, done
`ifdef NESTED_LOOP_STALL_CNT_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/loop_idx_cnt.sv
// One loop level: index register that advances on en, wraps to zero by
// compare-equal against the inclusive limit, and clears on clr.
module loop_idx_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] idx,
    output logic         at_limit
);

    logic [W-1:0] r_idx;
    logic         w_at_limit;

    assign w_at_limit = (r_idx == limit);

    // Index register: clear beats advance; wrap never relies on overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= {W{1'b0}};
        end else if (clr) begin
            r_idx <= {W{1'b0}};
        end else if (en) begin
            r_idx <= w_at_limit ? {W{1'b0}} : (r_idx + W'(1));
        end else begin
            r_idx <= r_idx;
        end
    end

    assign idx      = r_idx;
    assign at_limit = w_at_limit;

endmodule

// File: rtl/nested_loop_ctrl.sv
// Two-level loop sequencer: latches limits on start, emits one step per
// non-stalled RUN cycle, pulses done after the final step.
// Optional stall counter: NESTED_LOOP_STALL_CNT_EN.
module nested_loop_ctrl
    import mfcc_loop_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int OUT_CNT_W = CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    nested_loop_ctrl_if.slave  bus
);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [CNT_W-1:0]     r_inner_lim;
    logic [OUT_CNT_W-1:0] r_outer_lim;
    logic [CNT_W-1:0]     w_inner_idx;
    logic [OUT_CNT_W-1:0] w_outer_idx;
    logic                 w_inner_at;
    logic                 w_outer_at;
    logic                 w_run;
    logic                 w_step;
    logic                 w_final;
    logic                 w_accept;
    logic                 w_clr;
    logic                 w_inner_en;
    logic                 w_outer_en;

    assign w_run      = (r_state == ST_RUN);
    assign w_step     = w_run & ~bus.stall;
    assign w_final    = w_inner_at & w_outer_at;
    assign w_accept   = (r_state == ST_IDLE) & bus.start & ~bus.abort;
    assign w_clr      = w_accept | bus.abort | (r_state == ST_DONE);
    // On the final step both indices hold so the last pair stays visible
    assign w_inner_en = w_step & ~w_final;
    assign w_outer_en = w_step & w_inner_at & ~w_outer_at;

    // Next-state decode; abort outranks every other transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.abort) begin
                    w_next_state = ST_IDLE;
                end else if (bus.start) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_step && w_final) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Limits are captured only when a start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inner_lim <= {CNT_W{1'b0}};
            r_outer_lim <= {OUT_CNT_W{1'b0}};
        end else if (w_accept) begin
            r_inner_lim <= bus.inner_limit;
            r_outer_lim <= bus.outer_limit;
        end else begin
            r_inner_lim <= r_inner_lim;
            r_outer_lim <= r_outer_lim;
        end
    end

    loop_idx_cnt #(.W(CNT_W)) u_inner (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_inner_en),
        .clr      (w_clr),
        .limit    (r_inner_lim),
        .idx      (w_inner_idx),
        .at_limit (w_inner_at)
    );

    loop_idx_cnt #(.W(OUT_CNT_W)) u_outer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_outer_en),
        .clr      (w_clr),
        .limit    (r_outer_lim),
        .idx      (w_outer_idx),
        .at_limit (w_outer_at)
    );

`ifdef NESTED_LOOP_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Stalled RUN cycles since the last accepted start, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (w_accept) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (w_run && bus.stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

    assign bus.step_valid = w_step;
    assign bus.inner_idx  = w_inner_idx;
    assign bus.outer_idx  = w_outer_idx;
    assign bus.inner_last = w_run & w_inner_at;
    assign bus.outer_last = w_run & w_outer_at;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);

endmodule
